// File: rtl/ysyx_23060203_ifu.sv
// rtl/ysyx_23060203_ifu.sv - instruction fetch unit with a single outstanding read
// Fetches one instruction, hands it to the decoder, then waits for execute to supply the next PC.
module ysyx_23060203_ifu #(
   parameter logic [31:0] RESET_PC = 32'h80000000
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        fetch_err,
   input  logic        dnpc_valid,
   input  logic [31:0] dnpc,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_EXEC
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic        err_q;
   logic [31:0] fetch_cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         inst_q      <= 32'h0;
         err_q       <= 1'b0;
         fetch_cnt_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (state_q == S_WAIT && rvalid) begin
            inst_q      <= rdata;
            err_q       <= (rresp != 2'b00);
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         // Next PC is word-aligned; low bits from execute are dropped.
         if (state_q == S_EXEC && dnpc_valid) begin
            pc_q <= {dnpc[31:2], 2'b00};
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      arvalid   = 1'b0;
      rready    = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            arvalid = 1'b1;
            if (arready) state_d = S_WAIT;
         end
         S_WAIT: begin
            rready = 1'b1;
            if (rvalid) state_d = S_HOLD;
         end
         S_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_EXEC;
         end
         S_EXEC: begin
            if (dnpc_valid) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign araddr    = pc_q;
   assign pc        = pc_q;
   assign inst      = inst_q;
   assign fetch_err = err_q;
   assign fetch_cnt = fetch_cnt_q;

endmodule

// File: doc/ysyx_23060203_ifu.md
YSYX_23060203_IFU -- requirements
Module: ysyx_23060203_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h80000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port araddr, output, 32, instruction read address.
REQ-005 SHALL have port arvalid, output, 1, read-address valid.
REQ-006 SHALL have port arready, input, 1, read-address ready from memory.
REQ-007 SHALL have port rdata, input, 32, read data.
REQ-008 SHALL have port rresp, input, 2, read response; 2'b00 means OKAY.
REQ-009 SHALL have port rvalid, input, 1, read-data valid.
REQ-010 SHALL have port rready, output, 1, read-data ready.
REQ-011 SHALL have port inst, output, 32, fetched instruction to the decoder.
REQ-012 SHALL have port pc, output, 32, address of inst.
REQ-013 SHALL have port out_valid, output, 1, inst/pc valid toward the decoder.
REQ-014 SHALL have port out_ready, input, 1, decoder/execute accepts inst.
REQ-015 SHALL have port fetch_err, output, 1, a non-OKAY rresp accompanied inst.
REQ-016 SHALL have port dnpc_valid, input, 1, the execute stage has finished the current instruction.
REQ-017 SHALL have port dnpc, input, 32, next PC supplied with dnpc_valid.
REQ-018 SHALL have port fetch_cnt, output, 32, count of completed fetches.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, EXEC; arvalid=1 only in REQ, rready=1 only in WAIT, out_valid=1 only in HOLD, all combinational from state.
REQ-020 SHALL transition IDLE->REQ unconditionally on the first clock after reset deasserts.
REQ-021 SHALL transition REQ->WAIT on arvalid&&arready, else stay in REQ.
REQ-022 SHALL hold araddr equal to pc while in REQ, and keep pc constant from entry to REQ until the dnpc load.
REQ-023 SHALL ignore rvalid outside WAIT; a response arriving in the same cycle as the address handshake is not accepted.
REQ-024 SHALL, on rvalid&&rready in WAIT, capture inst<=rdata, fetch_err<=(rresp!=2'b00), fetch_cnt<=fetch_cnt+1 (mod 2^32 wrap), and go to HOLD.
REQ-025 SHALL hold inst, pc, and fetch_err stable in HOLD and EXEC.
REQ-026 SHALL transition HOLD->EXEC on out_valid&&out_ready, else stay in HOLD.
REQ-027 SHALL, in EXEC, on dnpc_valid load pc<={dnpc[31:2],2'b00} and go to REQ; otherwise stay in EXEC.
REQ-028 SHALL ignore dnpc_valid in every state except EXEC, including when it is asserted in the same cycle as the HOLD->EXEC handshake.
REQ-029 SHALL give a minimum latency of 2 cycles from the REQ handshake cycle to out_valid (REQ, WAIT with rvalid=1, HOLD), and 1 cycle from dnpc_valid to the next arvalid.
REQ-030 SHALL have at most one fetch outstanding, with no speculative or next-line prefetch.

Reset
REQ-031 SHALL, on reset high at a clock edge, force state=IDLE, pc=RESET_PC, inst=0, fetch_err=0, and fetch_cnt=0, giving arvalid=0, rready=0, and out_valid=0.
REQ-032 SHALL let reset asserted mid-transaction (REQ/WAIT/HOLD/EXEC) abandon it; any rvalid seen afterwards in IDLE/REQ is ignored.
REQ-033 SHALL give reset priority over every handshake in the same cycle.

Verification
REQ-034 SHALL cover basic fetch: reset, arready=1, rvalid=1 with rdata=32'h00000413 one cycle after the handshake -> araddr=80000000, then out_valid=1 with inst=00000413, pc=80000000, and fetch_cnt=1.
REQ-035 SHALL cover backpressure: arready held 0 for 3 cycles, then out_ready held 0 for 4 cycles -> arvalid stays 1 with araddr stable, and out_valid/inst stay stable until the handshake.
REQ-036 SHALL cover redirect: dnpc=32'h80000103 with dnpc_valid in EXEC -> the next arvalid carries araddr=80000100; dnpc_valid pulsed in HOLD -> no effect.
REQ-037 SHALL cover error response: rresp=2'b10 with rdata=0 -> out_valid=1 with fetch_err=1; the next fetch with rresp=0 -> fetch_err=0.
REQ-038 SHALL cover reset in WAIT: reset pulsed while rready=1, then rvalid=1 during IDLE -> no capture, pc=80000000, and fetch_cnt=0.
REQ-039 SHALL cover counter wrap: fetch_cnt preloaded via 2^32 fetches, or forced to FFFFFFFF in simulation, plus one fetch -> fetch_cnt=0.
